ntt8_butterfly_engine: RTL

- Iterative radix-2 decimation-in-time NTT engine for an 8-point vector of 8-bit residues.
- Sits directly downstream of the combinational bit-reverse permutation stage. It consumes the bit-reversed vector and produces the transform in natural order.
- Computes one butterfly per clock: 3 stages × 4 butterflies = 12 compute cycles.
- Uses a valid/ready handshake on both input and output, and holds one transform at a time.

---
 rtl/ntt8_butterfly_engine.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ntt8_butterfly_engine.sv
// rtl/ntt8_butterfly_engine.sv - iterative 8-point radix-2 DIT NTT, one butterfly per clock
// Optional inverse transform (inv port, SCALE state) enabled by `define NTT8_INVERSE_EN.
module ntt8_butterfly_engine #(
   parameter int Q    = 17,
   parameter int ROOT = 2
`ifdef NTT8_INVERSE_EN
   ,
   parameter int ROOT_INV = 9,
   parameter int N_INV    = 15
`endif
) (
   input  logic       clk,
   input  logic       rst,
`ifdef NTT8_INVERSE_EN
   input  logic       inv,
`endif
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] data_in [8],
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] data_out [8]
);

   localparam logic [7:0]  Q8  = 8'(Q);
   localparam logic [8:0]  Q9  = 9'(Q);
   localparam logic [15:0] Q16 = 16'(Q);

   function automatic logic [7:0] powmod(input int base, input int e);
      int r;
      r = 1;
      for (int i = 0; i < e; i++) r = (r * base) % Q;
      return 8'(r);
   endfunction

   function automatic logic [7:0] mulmod(input logic [7:0] x, input logic [7:0] y);
      logic [15:0] p;
      p = (16'(x) * 16'(y)) % Q16;
      return 8'(p);
   endfunction

   localparam logic [7:0] TW0 = powmod(ROOT, 0);
   localparam logic [7:0] TW1 = powmod(ROOT, 1);
   localparam logic [7:0] TW2 = powmod(ROOT, 2);
   localparam logic [7:0] TW3 = powmod(ROOT, 3);
`ifdef NTT8_INVERSE_EN
   localparam logic [7:0] ITW0 = powmod(ROOT_INV, 0);
   localparam logic [7:0] ITW1 = powmod(ROOT_INV, 1);
   localparam logic [7:0] ITW2 = powmod(ROOT_INV, 2);
   localparam logic [7:0] ITW3 = powmod(ROOT_INV, 3);
   localparam logic [7:0] NINV8 = 8'(N_INV);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPUTE,
`ifdef NTT8_INVERSE_EN
      S_SCALE,
`endif
      S_DONE
   } state_t;

   state_t     state, state_n;
   logic [7:0] a     [8];
   logic [7:0] a_nxt [8];
   logic [1:0] s, b;
   logic [2:0] j, jm;
   logic [1:0] k;
   logic [7:0] w, t;
   logic [8:0] sum, dif;
   logic       last;
`ifdef NTT8_INVERSE_EN
   logic       inv_r;
   logic [7:0] a_scl [8];
`endif

   assign last      = (s == 2'd2) && (b == 2'd3);
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    if (in_valid) state_n = S_COMPUTE;
`ifdef NTT8_INVERSE_EN
         S_COMPUTE: if (last) state_n = inv_r ? S_SCALE : S_DONE;
         S_SCALE:   state_n = S_DONE;
`else
         S_COMPUTE: if (last) state_n = S_DONE;
`endif
         S_DONE:    if (out_ready) state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   // Operand pair and twiddle exponent for butterfly b of stage s (half-span 2^s).
   always_comb begin
      case (s)
         2'd0:    begin j = {b, 1'b0};             jm = j + 3'd1; k = 2'd0;         end
         2'd1:    begin j = {b[1], 1'b0, b[0]};    jm = j + 3'd2; k = {b[0], 1'b0}; end
         default: begin j = {1'b0, b};             jm = j + 3'd4; k = b;            end
      endcase
      case (k)
         2'd0:    w = TW0;
         2'd1:    w = TW1;
         2'd2:    w = TW2;
         default: w = TW3;
      endcase
`ifdef NTT8_INVERSE_EN
      if (inv_r) begin
         case (k)
            2'd0:    w = ITW0;
            2'd1:    w = ITW1;
            2'd2:    w = ITW2;
            default: w = ITW3;
         endcase
      end
`endif
      t   = mulmod(a[jm], w);
      sum = {1'b0, a[j]} + {1'b0, t};
      if (sum >= Q9) sum = sum - Q9;
      dif = {1'b0, a[j]} + Q9 - {1'b0, t};
      if (dif >= Q9) dif = dif - Q9;
      a_nxt     = a;
      a_nxt[j]  = sum[7:0];
      a_nxt[jm] = dif[7:0];
   end

`ifdef NTT8_INVERSE_EN
   always_comb begin
      for (int i = 0; i < 8; i++) a_scl[i] = mulmod(a[i], NINV8);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            a[i]        <= '0;
            data_out[i] <= '0;
         end
         s <= '0;
         b <= '0;
`ifdef NTT8_INVERSE_EN
         inv_r <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < 8; i++) a[i] <= data_in[i] % Q8;
                  s <= '0;
                  b <= '0;
`ifdef NTT8_INVERSE_EN
                  inv_r <= inv;
`endif
               end
            end
            S_COMPUTE: begin
               a <= a_nxt;
               b <= b + 2'd1;
               if (b == 2'd3) s <= s + 2'd1;
`ifdef NTT8_INVERSE_EN
               if (last && !inv_r) data_out <= a_nxt;
`else
               if (last) data_out <= a_nxt;
`endif
            end
`ifdef NTT8_INVERSE_EN
            S_SCALE: begin
               a        <= a_scl;
               data_out <= a_scl;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
